// File: rtl/booth_mul_seq_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM states,
// Booth recoding operations and the recoding decode helper.
package booth_mul_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      BOOTH_NOP = 2'd0,
      BOOTH_ADD = 2'd1,
      BOOTH_SUB = 2'd2
   } booth_op_e;

   // Radix-2 Booth recoding of the pair {Q[0], q_1}.
   function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
      booth_op_e op;
      case ({q0, q_1})
         2'b01:   op = BOOTH_ADD;
         2'b10:   op = BOOTH_SUB;
         default: op = BOOTH_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_mul_seq_rca_add_sub.sv
// Ripple-carry adder/subtractor: s = a + b + cin when con=0,
// s = a + ~b + 1 when con=1 (cin is overridden by con).
module rca_add_sub #(
   parameter int n = 8
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         cin,
   input  logic         con,
   output logic [n-1:0] s,
   output logic         cout
);

   logic [n:0]   c;
   logic [n-1:0] bx;

   assign bx   = b ^ {n{con}};
   assign c[0] = cin | con;

   for (genvar i = 0; i < n; i++) begin : g_fa
      assign s[i]   = a[i] ^ bx[i] ^ c[i];
      assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
   end

   assign cout = c[n];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier: N iterations through one
// shared (N+1)-bit add/sub unit, then a one-cycle done pulse.
module booth_mul_seq
   import booth_mul_seq_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = $clog2(N + 1);

   state_e           state_q, state_d;
   logic [N:0]       a_q, a_d;
   logic [N:0]       m_q, m_d;
   logic [N-1:0]     q_q, q_d;
   logic             q1_q, q1_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*N-1:0]   product_q, product_d;
   logic             done_q, done_d;

   booth_op_e        op;
   logic             add_con;
   logic [N:0]       add_s;
   logic             add_cout_unused;
   logic [N:0]       s;
   logic [N:0]       a_shift;
   logic [N-1:0]     q_shift;

   rca_add_sub #(.n(N + 1)) u_addsub (
      .a    (a_q),
      .b    (m_q),
      .cin  (1'b0),
      .con  (add_con),
      .s    (add_s),
      .cout (add_cout_unused)
   );

   always_comb begin
      op      = booth_decode(q_q[0], q1_q);
      add_con = (op == BOOTH_SUB);
      s       = (op == BOOTH_NOP) ? a_q : add_s;
      a_shift = {s[N], s[N:1]};
      q_shift = {s[0], q_q[N-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      m_d       = m_q;
      q_d       = q_q;
      q1_d      = q1_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_CALC;
               m_d     = {multiplicand[N-1], multiplicand};
               a_d     = '0;
               q_d     = multiplier;
               q1_d    = 1'b0;
               cnt_d   = CW'(N);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            a_d   = a_shift;
            q_d   = q_shift;
            q1_d  = q_q[0];
            cnt_d = cnt_q - CW'(1);
            // Product is taken from the post-shift values of the final iteration.
            if (cnt_q == CW'(1)) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               product_d = {a_shift[N-1:0], q_shift};
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         m_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         m_q       <= m_d;
         q_q       <= q_d;
         q1_q      <= q1_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign ready   = (state_q != ST_CALC);
   assign busy    = (state_q == ST_CALC);
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed corners, random operands
// against an arithmetic reference, start-while-busy, back-to-back and async reset.
module tb_booth_mul_seq;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [N-1:0]   multiplicand;
   logic [N-1:0]   multiplier;
   logic           ready;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int compared   = 0;
   int mismatched = 0;

   booth_mul_seq #(.N(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .ready        (ready),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   function automatic logic [2*N-1:0] model_mul(input logic [N-1:0] m, input logic [N-1:0] q);
      longint p;
      p = longint'($signed(m)) * longint'($signed(q));
      return p[2*N-1:0];
   endfunction

   // Issues one start, scrambles the operand inputs after acceptance and waits
   // (bounded) for done; reports latency in edges after acceptance and busy cycles.
   task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q,
                         output logic [2*N-1:0] p, output int lat,
                         output int busy_cnt, output bit timed_out);
      @(negedge clk);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      @(posedge clk); #1;
      start        = 1'b0;
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      lat = 0; busy_cnt = 0; timed_out = 1'b1; p = '0;
      for (int i = 0; i < 4 * N; i++) begin
         if (busy) busy_cnt++;
         if (done) begin
            timed_out = 1'b0;
            p = product;
            break;
         end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      #12;
      compared++;
      if ({ready, busy, done} !== 3'b100) begin
         mismatched++;
         $display("FAIL reset_flags: got ready/busy/done=%b expected 100", {ready, busy, done});
      end
      compared++;
      if (product !== '0) begin
         mismatched++;
         $display("FAIL reset_product: got %h expected 0000", product);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      logic [N-1:0]   tm [4] = '{8'd3, 8'hFD, 8'd127, 8'h80};
      logic [N-1:0]   tq [4] = '{8'd5, 8'd5, 8'h80, 8'h80};
      logic [2*N-1:0] te [4] = '{16'h000F, 16'hFFF1, 16'hC080, 16'h4000};
      logic [2*N-1:0] p;
      int lat, bc;
      bit to;
      for (int k = 0; k < 4; k++) begin
         run_op(tm[k], tq[k], p, lat, bc, to);
         compared++;
         if (to) begin
            mismatched++;
            $display("FAIL directed_timeout[%0d]: got no done expected done within %0d cycles", k, 4 * N);
         end
         compared++;
         if (p !== te[k]) begin
            mismatched++;
            $display("FAIL directed_product[%0d]: got %h expected %h", k, p, te[k]);
         end
         compared++;
         if (lat !== N || bc !== N) begin
            mismatched++;
            $display("FAIL directed_timing[%0d]: got lat=%0d busy=%0d expected %0d/%0d", k, lat, bc, N, N);
         end
         @(posedge clk); #1;
         compared++;
         if (done !== 1'b0 || ready !== 1'b1 || product !== te[k]) begin
            mismatched++;
            $display("FAIL directed_after_done[%0d]: got done=%b ready=%b product=%h expected 0/1/%h",
                     k, done, ready, product, te[k]);
         end
      end
   endtask

   task automatic test_random;
      logic [N-1:0]   m, q;
      logic [2*N-1:0] p, e;
      int lat, bc;
      bit to;
      for (int k = 0; k < 24; k++) begin
         m = N'($urandom);
         q = N'($urandom);
         if (k == 0) m = 8'h80;
         if (k == 1) q = 8'h00;
         if (k == 2) begin m = 8'h7F; q = 8'h7F; end
         if (k == 3) begin m = 8'hFF; q = 8'h80; end
         e = model_mul(m, q);
         run_op(m, q, p, lat, bc, to);
         compared++;
         if (to || p !== e || lat !== N) begin
            mismatched++;
            $display("FAIL random[%0d] %h*%h: got %h (lat=%0d timeout=%0b) expected %h (lat=%0d)",
                     k, m, q, p, lat, to, e, N);
         end
      end
   endtask

   task automatic test_start_while_busy;
      logic [2*N-1:0] e;
      int lat;
      bit seen;
      e = model_mul(8'd7, 8'd9);
      @(negedge clk);
      multiplicand = 8'd7;
      multiplier   = 8'd9;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      repeat (2) begin @(posedge clk); #1; lat++; end
      start        = 1'b1;
      multiplicand = 8'hFB;
      multiplier   = 8'd11;
      @(posedge clk); #1; lat++;
      start = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 4 * N; i++) begin
         if (done) begin seen = 1'b1; break; end
         @(posedge clk); #1; lat++;
      end
      compared++;
      if (!seen || product !== e || lat !== N) begin
         mismatched++;
         $display("FAIL busy_start_ignored: got product=%h lat=%0d done=%0b expected %h lat=%0d",
                  product, lat, seen, e, N);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [2*N-1:0] expq [$];
      logic [2*N-1:0] e;
      int cyc, last, guard;
      cyc  = 0;
      last = -1;
      @(negedge clk);
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      start        = 1'b1;
      expq.push_back(model_mul(multiplicand, multiplier));
      @(posedge clk); #1;
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      for (int k = 0; k < 4; k++) begin
         guard = 0;
         while (!done && guard < 4 * N) begin
            @(posedge clk); #1;
            cyc++; guard++;
         end
         compared++;
         if (!done) begin
            mismatched++;
            $display("FAIL b2b_timeout[%0d]: got no done expected done within %0d cycles", k, 4 * N);
         end
         e = expq.pop_front();
         compared++;
         if (product !== e) begin
            mismatched++;
            $display("FAIL b2b_product[%0d]: got %h expected %h", k, product, e);
         end
         if (last >= 0) begin
            compared++;
            if (cyc - last !== N + 1) begin
               mismatched++;
               $display("FAIL b2b_period[%0d]: got %0d expected %0d", k, cyc - last, N + 1);
            end
         end
         last = cyc;
         if (k < 3) begin
            expq.push_back(model_mul(multiplicand, multiplier));
            @(posedge clk); #1; cyc++;
            multiplicand = N'($urandom);
            multiplier   = N'($urandom);
         end else begin
            start = 1'b0;
            @(posedge clk); #1; cyc++;
         end
      end
      compared++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL b2b_idle: got ready=%b busy=%b expected 1/0", ready, busy);
      end
   endtask

   task automatic test_async_reset;
      logic [2*N-1:0] p, e;
      int lat, bc;
      bit to, saw_done;
      @(negedge clk);
      multiplicand = 8'd100;
      multiplier   = 8'd3;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      compared++;
      if (product !== '0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("FAIL async_reset_clear: got product=%h ready=%b busy=%b done=%b expected 0000/1/0/0",
                  product, ready, busy, done);
      end
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (N + 2) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      compared++;
      if (saw_done || product !== '0) begin
         mismatched++;
         $display("FAIL async_reset_no_done: got done_seen=%0b product=%h expected 0/0000", saw_done, product);
      end
      e = model_mul(8'hE7, 8'h3C);
      run_op(8'hE7, 8'h3C, p, lat, bc, to);
      compared++;
      if (to || p !== e) begin
         mismatched++;
         $display("FAIL async_reset_recover: got %h (timeout=%0b) expected %h", p, to, e);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_while_busy();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
